// File: rtl/axi_lite_pkg.sv
// Shared encodings for the AXI-lite master: controller states and response codes.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // resp[1] separates the error codes (SLVERR/DECERR) from the good ones.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi_lite_m.sv
// Single-outstanding AXI-lite master: one CPU request in, one AXI read or write out,
// one-cycle completion pulse back. R and W paths share a single state register.
module axi_lite_m
  import axi_lite_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 64,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_req_ready;
  logic                r_arvalid, r_rready;
  logic                r_awvalid, r_wvalid, r_bready;
  logic                r_aw_done, r_w_done;
  logic                r_rsp_valid, r_rsp_err;
  logic [DATA_W-1:0]   r_rsp_rdata;

  logic w_aw_hs, w_w_hs, w_aw_fin, w_w_fin;

  assign w_aw_hs  = r_awvalid & awready;
  assign w_w_hs   = r_wvalid & wready;
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done | w_w_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_req_ready <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // req_ready comes up one edge after reset release, then stays up while idle.
          if (!r_req_ready) begin
            r_req_ready <= 1'b1;
          end else if (req_valid) begin
            r_req_ready <= 1'b0;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_wstrb     <= req_wstrb;
            if (req_wen) begin
              r_state   <= S_WR_REQ;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end else begin
              r_state   <= S_RD_ADDR;
              r_arvalid <= 1'b1;
            end
          end
        end
        S_RD_ADDR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= rdata;
            r_rsp_err   <= resp_is_err(rresp);
            r_rsp_valid <= 1'b1;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_WR_REQ: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          // AW and W may complete in either order or together.
          if (w_aw_fin && w_w_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_err   <= resp_is_err(bresp);
            r_rsp_valid <= 1'b1;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign araddr    = r_addr;
  assign arvalid   = r_arvalid;
  assign rready    = r_rready;
  assign awaddr    = r_addr;
  assign awvalid   = r_awvalid;
  assign wdata     = r_wdata;
  assign wstrb     = r_wstrb;
  assign wvalid    = r_wvalid;
  assign bready    = r_bready;

endmodule

// File: tb/tb_axi_lite_m.sv
// Directed + random bench for axi_lite_m with a delay-programmable AXI-lite slave.
module tb_axi_lite_m;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic [31:0] araddr, awaddr;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [63:0] rdata = '0, wdata;
  logic [7:0]  wstrb;
  logic [1:0]  rresp = '0, bresp = '0;

  axi_lite_m #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // slave configuration
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [63:0] s_rdata = '0;
  logic [1:0]  s_rresp = '0, s_bresp = '0;
  bit s_data_from_addr = 0, spurious = 0;

  // slave state
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  bit r_pend = 0, aw_got = 0, w_got = 0, b_pend = 0;
  bit hs_ar = 0, hs_r = 0, hs_aw = 0, hs_w = 0, hs_b = 0;

  // monitor state
  int cyc = 0, proto_err = 0;
  int acc_q[$];
  int rsp_cyc_q[$];
  logic [63:0] rsp_data_q[$];
  logic rsp_err_q[$];
  logic [31:0] log_araddr = '0, log_awaddr = '0;
  logic [63:0] log_wdata = '0;
  logic [7:0]  log_wstrb = '0;
  bit p_ar_wait = 0, p_aw_wait = 0, p_w_wait = 0, p_rsp = 0;
  logic [31:0] p_araddr = '0, p_awaddr = '0;
  logic [63:0] p_wdata = '0;
  logic [7:0]  p_wstrb = '0;

  function automatic logic [63:0] addr_data(input logic [31:0] a);
    return {a, a ^ 32'hA5A5_5A5A};
  endfunction

  // Handshake bookkeeping and protocol rules, sampled on the edge itself.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
      p_ar_wait = 0; p_aw_wait = 0; p_w_wait = 0; p_rsp = 0;
    end else begin
      if (hs_ar && arvalid) proto_err++;
      if (hs_aw && awvalid) proto_err++;
      if (hs_w && wvalid) proto_err++;
      if (p_ar_wait && !(arvalid && araddr == p_araddr)) proto_err++;
      if (p_aw_wait && !(awvalid && awaddr == p_awaddr)) proto_err++;
      if (p_w_wait && !(wvalid && wdata == p_wdata && wstrb == p_wstrb)) proto_err++;
      if (req_ready && (arvalid || rready || awvalid || wvalid || bready)) proto_err++;
      if (rsp_valid && p_rsp) proto_err++;
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready;
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      hs_b  = bvalid && bready;
      p_ar_wait = arvalid && !arready; p_araddr = araddr;
      p_aw_wait = awvalid && !awready; p_awaddr = awaddr;
      p_w_wait  = wvalid && !wready;   p_wdata = wdata; p_wstrb = wstrb;
      p_rsp = rsp_valid;
      if (hs_ar) log_araddr = araddr;
      if (hs_aw) log_awaddr = awaddr;
      if (hs_w) begin log_wdata = wdata; log_wstrb = wstrb; end
      if (req_valid && req_ready) acc_q.push_back(cyc);
      if (rsp_valid) begin
        rsp_cyc_q.push_back(cyc);
        rsp_data_q.push_back(rsp_rdata);
        rsp_err_q.push_back(rsp_err);
      end
    end
  end

  // Slave: each ready rises after its programmed number of waiting cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
    end else begin
      if (hs_ar) begin
        arready = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0;
        rdata = s_data_from_addr ? addr_data(log_araddr) : s_rdata;
        rresp = s_rresp;
      end else if (arvalid) begin
        arready = (ar_cnt >= ar_dly); ar_cnt++;
      end else begin
        arready = 0; ar_cnt = 0;
      end
      if (hs_r) begin r_pend = 0; rvalid = 0; end
      else if (r_pend) begin if (r_cnt >= r_dly) rvalid = 1; else r_cnt++; end
      else rvalid = spurious;
      if (hs_aw) begin awready = 0; aw_got = 1; aw_cnt = 0; end
      else if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
      else begin awready = 0; aw_cnt = 0; end
      if (hs_w) begin wready = 0; w_got = 1; w_cnt = 0; end
      else if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; end
      else begin wready = 0; w_cnt = 0; end
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0; bresp = s_bresp;
      end
      if (hs_b) begin b_pend = 0; bvalid = 0; end
      else if (b_pend) begin if (b_cnt >= b_dly) bvalid = 1; else b_cnt++; end
      else bvalid = spurious;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  logic [63:0] exp_rdata = '0;

  // One request; d0/d1 are AR/R delays on reads, AW/W delays on writes; d2 is B delay.
  task automatic do_txn(input string tag, input bit wen, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [7:0] ws, input logic [1:0] resp,
                        input logic [63:0] rd, input int d0, input int d1, input int d2);
    bit ok;
    int lat, exp_lat, a_c, r_c;
    logic [63:0] got_d;
    logic got_e;
    if (wen) begin aw_dly = d0; w_dly = d1; b_dly = d2; s_bresp = resp; end
    else begin ar_dly = d0; r_dly = d1; s_rresp = resp; s_rdata = rd; end
    req_wen = wen; req_addr = addr; req_wdata = wd; req_wstrb = ws; req_valid = 1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    chk({tag, "_accept"}, ok, 1);
    @(posedge clk); @(negedge clk);
    req_valid = 0;
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      if (rsp_data_q.size() > 0) begin ok = 1; break; end
      @(negedge clk);
    end
    chk({tag, "_rsp_seen"}, ok, 1);
    if (ok && acc_q.size() > 0) begin
      a_c = acc_q.pop_front(); r_c = rsp_cyc_q.pop_front();
      got_d = rsp_data_q.pop_front(); got_e = rsp_err_q.pop_front();
      lat = r_c - a_c;
      if (wen) exp_lat = 3 + ((d0 > d1) ? d0 : d1) + d2;
      else begin exp_lat = 3 + d0 + d1; exp_rdata = rd; end
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_err"}, got_e, resp[1]);
      chk({tag, "_rdata"}, got_d, exp_rdata);
      if (wen) begin
        chk({tag, "_awaddr"}, log_awaddr, addr);
        chk({tag, "_wdata"}, log_wdata, wd);
        chk({tag, "_wstrb"}, log_wstrb, ws);
      end else chk({tag, "_araddr"}, log_araddr, addr);
    end
    @(negedge clk);
    chk({tag, "_single_pulse"}, rsp_data_q.size(), 0);
  endtask

  logic [31:0] b2b_addr [3];

  initial begin
    bit ok;
    int a_c [3];
    int r_c [3];
    logic [63:0] d;

    #1 rst_n = 0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready_bready", {rready, bready}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_wdata", wdata, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk); @(negedge clk);
    chk("idle_req_ready", req_ready, 1);

    do_txn("rd_basic", 0, 32'h8000_0000, '0, '0, 2'b00, 64'h1122_3344_5566_7788, 0, 0, 0);
    do_txn("rd_bp", 0, 32'h8000_0040, '0, '0, 2'b01, 64'hCAFE_F00D_0BAD_BEEF, 4, 3, 0);
    do_txn("wr_split", 1, 32'h8000_0010, 64'hDEAD_BEEF, 8'h0F, 2'b00, '0, 0, 4, 0);
    do_txn("wr_slverr", 1, 32'h8000_0018, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b10, '0, 2, 0, 1);
    do_txn("rd_decerr", 0, 32'h8000_0020, '0, '0, 2'b11, 64'h0F0F_0F0F_F0F0_F0F0, 0, 1, 0);

    // stray R/B beats while idle must not be taken
    spurious = 1;
    repeat (4) @(negedge clk);
    chk("spur_ready", {rready, bready}, 0);
    chk("spur_no_rsp", rsp_data_q.size(), 0);
    spurious = 0;
    @(negedge clk); @(negedge clk);

    // reset while the read waits in RD_DATA
    r_dly = 20; ar_dly = 0; s_rdata = 64'h5555_AAAA_5555_AAAA; s_rresp = 2'b00;
    req_wen = 0; req_addr = 32'h8000_0080; req_valid = 1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (rready) begin ok = 1; break; end
      @(negedge clk);
      req_valid = 0;
    end
    chk("mid_rst_reach_rd_data", ok, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    repeat (25) @(negedge clk);
    chk("mid_rst_no_rsp", rsp_data_q.size(), 0);
    acc_q.delete();
    exp_rdata = '0;
    chk("mid_rst_rdata_cleared", rsp_rdata, 0);
    do_txn("rd_after_rst", 0, 32'h8000_0088, '0, '0, 2'b00, 64'h1357_9BDF_2468_ACE0, 1, 0, 0);

    // back-to-back reads with req_valid held high
    s_data_from_addr = 1; ar_dly = 0; r_dly = 0;
    b2b_addr[0] = 32'h9000_0000; b2b_addr[1] = 32'h9000_0100; b2b_addr[2] = 32'h9000_0200;
    req_wen = 0; req_valid = 1;
    for (int k = 0; k < 3; k++) begin
      req_addr = b2b_addr[k];
      ok = 0;
      for (int i = 0; i < 40; i++) begin
        if (req_ready) begin ok = 1; break; end
        @(negedge clk);
      end
      chk("b2b_accept", ok, 1);
      @(posedge clk); @(negedge clk);
    end
    req_valid = 0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_data_q.size() >= 3) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("b2b_three_rsp", ok, 1);
    if (ok && acc_q.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        a_c[k] = acc_q.pop_front(); r_c[k] = rsp_cyc_q.pop_front();
        d = rsp_data_q.pop_front(); void'(rsp_err_q.pop_front());
        chk("b2b_order_data", d, addr_data(b2b_addr[k]));
        chk("b2b_latency", r_c[k] - a_c[k], 3);
      end
      chk("b2b_accept_on_rsp_0", a_c[1], r_c[0]);
      chk("b2b_accept_on_rsp_1", a_c[2], r_c[1]);
      exp_rdata = addr_data(b2b_addr[2]);
    end else chk("b2b_accept_count", acc_q.size(), 3);
    acc_q.delete(); rsp_cyc_q.delete(); rsp_data_q.delete(); rsp_err_q.delete();
    s_data_from_addr = 0;
    @(negedge clk);

    // random mix
    for (int n = 0; n < 24; n++) begin
      do_txn($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), $urandom,
             {$urandom, $urandom}, 8'($urandom), 2'($urandom_range(0, 3)),
             {$urandom, $urandom}, $urandom_range(0, 4), $urandom_range(0, 4),
             $urandom_range(0, 3));
    end

    chk("protocol_rules", proto_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/axi_lite_m.md
AXI_LITE_M -- requirements
Module: axi_lite_m

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning data width; STRB_W = DATA_W/8.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  CPU-side request valid.
- req_ready  out  1  CPU-side request accepted.
- req_wen  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  STRB_W  write byte strobes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid on a read.
- rsp_err  out  1  resp[1] of the completing R/B beat.
- araddr, arvalid (out); arready (in)  AXI-lite read address channel.
- rdata, rresp[1:0], rvalid (in); rready (out)  AXI-lite read data channel.
- awaddr, awvalid (out); awready (in)  AXI-lite write address channel.
- wdata, wstrb, wvalid (out); wready (in)  AXI-lite write data channel.
- bresp[1:0], bvalid (in); bready (out)  AXI-lite write response channel.

Function
REQ-004 SHALL implement states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
REQ-005 SHALL drive req_ready=1 only in IDLE. On req_valid&req_ready, SHALL latch addr, wdata and wstrb, then enter RD_ADDR (req_wen=0) or WR_REQ (req_wen=1).
REQ-006 In RD_ADDR, SHALL hold arvalid=1 with a stable araddr until arready is sampled high, then enter RD_DATA; arvalid SHALL NOT drop before handshake.
REQ-007 In RD_DATA, SHALL hold rready=1. On rvalid, SHALL register rdata into rsp_rdata and rresp[1] into rsp_err, pulse rsp_valid the next cycle, and return to IDLE.
REQ-008 In WR_REQ, SHALL assert awvalid and wvalid together, then track aw_done and w_done flags independently.
- Each valid SHALL deassert in the cycle after its own handshake.
- When both are done (same cycle or different cycles), SHALL enter WR_RESP.
REQ-009 In WR_RESP, SHALL hold bready=1. On bvalid, SHALL set rsp_err=bresp[1], pulse rsp_valid the next cycle, and return to IDLE. rsp_rdata SHALL be unchanged on writes.
REQ-010 rsp_valid SHALL be high for exactly one cycle per request, with no backpressure. The earliest next acceptance SHALL be in the same cycle as rsp_valid.
REQ-011 Read latency SHALL be at least 3 cycles from acceptance to rsp_valid when arready and rvalid are each high on their first possible cycle. Write latency SHALL likewise be at least 3 cycles.
REQ-012 rvalid/bvalid arriving in a state other than RD_DATA/WR_RESP SHALL be ignored: rready/bready stay 0.
REQ-013 Outputs araddr, awaddr, wdata and wstrb SHALL come from registers; no CPU-side input SHALL combinationally reach an AXI output.
REQ-014 rresp/bresp 2'b10 (SLVERR) or 2'b11 SHALL set rsp_err=1; 2'b00/2'b01 SHALL give rsp_err=0.

Reset
REQ-015 On rst_n low, SHALL immediately (asynchronously) enter IDLE and clear all valid, ready and done flags, rsp_valid and rsp_err. rsp_rdata and the address/data registers SHALL clear to 0.
REQ-016 Reset mid-transaction SHALL abandon the transaction with no rsp_valid. The first acceptance after release SHALL be no earlier than the first clk edge with rst_n high.

Structure
REQ-017 Package axi_lite_pkg SHALL hold the state encoding and the resp constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
REQ-018 SHALL be a single module with no sub-module; the R and W paths share one state register.

Verification
REQ-019 Read: req addr 0x8000_0000 with a slave returning 0x1122_3344_5566_7788 and rresp=00 -> arvalid held until arready, rsp_valid pulse, rsp_rdata=0x1122334455667788, rsp_err=0.
REQ-020 Read backpressure: arready delayed 4 cycles and rvalid 3 further cycles -> araddr stable throughout, exactly one rsp_valid.
REQ-021 Write, split handshakes: addr 0x8000_0010, wdata 0xDEAD_BEEF, wstrb 0x0F; awready at cycle 1, wready at cycle 5 -> awvalid drops after cycle 1, wvalid stays up until cycle 5, bready follows, rsp_valid once.
REQ-022 Error: bresp=2'b10 on a write, then rresp=2'b11 on a read -> rsp_err=1 both times.
REQ-023 Reset: rst_n pulled low while in RD_DATA -> arvalid/rready/rsp_valid go 0 immediately; a new read after release completes normally.
REQ-024 Back-to-back: req_valid held high for 3 requests -> each accepted only in IDLE, and 3 rsp_valid pulses arrive in order.
